// File: rtl/fp16_to_int16_pipe.sv
// fp16_to_int16_pipe: two-stage IEEE-754 binary16 -> signed int16 converter.
// Stage 1 unpacks the operand; stage 2 shifts, rounds, negates and saturates.
// Valid/ready handshake on both sides; the pipe never drops or duplicates data.
// Optional build macro: FP2I_ROUND_NEAREST_EN selects round-to-nearest-even
// instead of the default round-toward-zero.
module fp16_to_int16_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_invalid,
    output logic        out_overflow,
    output logic        out_inexact
);

    localparam logic [1:0] CLS_ZERO = 2'd0;  // zero or subnormal
    localparam logic [1:0] CLS_NORM = 2'd1;
    localparam logic [1:0] CLS_INF  = 2'd2;
    localparam logic [1:0] CLS_NAN  = 2'd3;

    logic              s1_valid;
    logic              s1_sign;
    logic [10:0]       s1_sig;
    logic signed [5:0] s1_exp;   // unbiased exponent, -15..16
    logic [1:0]        s1_cls;

    logic       out_ld;
    logic [4:0] in_exp;
    logic [9:0] in_frac;
    logic [1:0] in_cls;

    // Output stage can take a new value when empty or being drained;
    // stage 1 can move whenever it is empty or its content moves on.
    assign out_ld   = !out_valid || out_ready;
    assign in_ready = !s1_valid || out_ld;

    assign in_exp  = in_data[14:10];
    assign in_frac = in_data[9:0];

    // Classify the incoming operand
    always_comb begin
        in_cls = CLS_NORM;
        if (in_exp == 5'd31)
            in_cls = (in_frac != 10'd0) ? CLS_NAN : CLS_INF;
        else if (in_exp == 5'd0)
            in_cls = CLS_ZERO;
    end

    // Stage 1 register: unpacked sign / significand / exponent / class
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sig   <= '0;
            s1_exp   <= '0;
            s1_cls   <= CLS_ZERO;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            s1_sign  <= in_data[15];
            s1_sig   <= {(in_exp != 5'd0), in_frac};
            s1_exp   <= $signed({1'b0, in_exp}) - 6'sd15;
            s1_cls   <= in_cls;
        end
    end

    logic [15:0] res;
    logic [15:0] mag;
    logic        res_inv;
    logic        res_ovf;
    logic        res_inx;
    logic [21:0] ext;      // {significand, 11 guard/sticky slots} after right shift
    logic [3:0]  rsh;
    logic [2:0]  lsh;
    logic        guard;
    logic        sticky;

    // Stage 2: shift, round, negate and saturate according to class
    always_comb begin
        res     = '0;
        mag     = '0;
        res_inv = 1'b0;
        res_ovf = 1'b0;
        res_inx = 1'b0;
        ext     = '0;
        rsh     = '0;
        lsh     = '0;
        guard   = 1'b0;
        sticky  = 1'b0;
        case (s1_cls)
            CLS_INF: begin
                res_inv = 1'b1;
                res     = s1_sign ? 16'h8000 : 16'h7FFF;
            end
            CLS_NAN: begin
                res_inv = 1'b1;
            end
            CLS_ZERO: begin
                res_inx = |s1_sig[9:0];
            end
            default: begin
                if (s1_exp >= 6'sd15) begin
                    // -32768 is the only representable value with E >= 15
                    if (s1_sign && s1_exp == 6'sd15 && s1_sig == 11'h400) begin
                        res = 16'h8000;
                    end else begin
                        res_ovf = 1'b1;
                        res     = s1_sign ? 16'h8000 : 16'h7FFF;
                    end
                end else if (s1_exp >= 6'sd10) begin
                    lsh = 3'(s1_exp - 6'sd10);
                    mag = {5'd0, s1_sig} << lsh;
                    res = s1_sign ? 16'(-mag) : mag;
                end else begin
                    if (s1_exp >= -6'sd1) begin
                        // E = -1 keeps the hidden bit as the guard bit
                        rsh    = 4'(6'sd10 - s1_exp);
                        ext    = {s1_sig, 11'd0} >> rsh;
                        mag    = {5'd0, ext[21:11]};
                        guard  = ext[10];
                        sticky = |ext[9:0];
                    end else begin
                        sticky = 1'b1;
                    end
                    res_inx = guard | sticky;
`ifdef FP2I_ROUND_NEAREST_EN
                    // ties to even; magnitude stays <= 1024, cannot overflow
                    mag = mag + {15'd0, guard & (sticky | mag[0])};
`endif
                    res = s1_sign ? 16'(-mag) : mag;
                end
            end
        endcase
    end

    // Output register: loads when empty or drained, holds under back-pressure
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            out_invalid  <= 1'b0;
            out_overflow <= 1'b0;
            out_inexact  <= 1'b0;
        end else if (out_ld) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data     <= res;
                out_invalid  <= res_inv;
                out_overflow <= res_ovf;
                out_inexact  <= res_inx;
            end
        end
    end

endmodule

// File: tb/tb_fp16_to_int16_pipe.sv
// Directed bench for fp16_to_int16_pipe: hand-computed vectors, a queue of
// expected results checked in order at the output, stall and reset cases.
module tb_fp16_to_int16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_invalid;
    logic        out_overflow;
    logic        out_inexact;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    bit lat_on = 1'b1;

    logic [18:0] cur_exp;
    logic [18:0] exp_q[$];
    int          cyc_q[$];

    fp16_to_int16_pipe dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_invalid (out_invalid),
        .out_overflow(out_overflow),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // expected value packing: {data, invalid, overflow, inexact}
    task automatic send(input logic [15:0] d, input logic [18:0] e);
        bit acc;
        int n;
        acc      = 1'b0;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        cur_exp  = e;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = in_ready;
            sync();
            n++;
        end
        if (!acc) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    // Scoreboard: record accepted operands, compare delivered results in order
    always @(negedge clk) begin
        logic [18:0] e;
        int c;
        if (!rst && in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
            cyc_q.push_back(cyc);
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                chk("result", {13'd0, out_data, out_invalid, out_overflow, out_inexact}, {13'd0, e});
                if (lat_on) chk("latency", cyc - c, 32'd2);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        cur_exp   = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out", {13'd0, out_data, out_invalid, out_overflow, out_inexact}, 32'd0);

        // basic stream
        sync();
        send(16'h3C00, {16'h0001, 3'b000});
        send(16'h4000, {16'h0002, 3'b000});
        send(16'hC500, {16'hFFFB, 3'b000});
        send(16'h0001, {16'h0000, 3'b001});
        repeat (4) sync();

        // rounding and special classes
`ifdef FP2I_ROUND_NEAREST_EN
        send(16'h4100, {16'h0002, 3'b001});
        send(16'h4300, {16'h0004, 3'b001});
        send(16'h3800, {16'h0000, 3'b001});
        send(16'h3BFF, {16'h0001, 3'b001});
        send(16'h3E00, {16'h0002, 3'b001});
        send(16'hBE00, {16'hFFFE, 3'b001});
`else
        send(16'h4100, {16'h0002, 3'b001});
        send(16'h4300, {16'h0003, 3'b001});
        send(16'h3800, {16'h0000, 3'b001});
        send(16'h3BFF, {16'h0000, 3'b001});
        send(16'h3E00, {16'h0001, 3'b001});
        send(16'hBE00, {16'hFFFF, 3'b001});
`endif
        send(16'h7800, {16'h7FFF, 3'b010});
        send(16'hF800, {16'h8000, 3'b000});
        send(16'h7BFF, {16'h7FFF, 3'b010});
        send(16'hFBFF, {16'h8000, 3'b010});
        send(16'h77FF, {16'h7FF0, 3'b000});
        send(16'h6400, {16'h0400, 3'b000});
        send(16'h7C00, {16'h7FFF, 3'b100});
        send(16'hFC00, {16'h8000, 3'b100});
        send(16'h7E00, {16'h0000, 3'b100});
        send(16'h8000, {16'h0000, 3'b000});
        send(16'hB800, {16'h0000, 3'b001});
        repeat (4) sync();

        // back-pressure: out_ready low while operands keep arriving
        lat_on    = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                send(16'h4000, {16'h0002, 3'b000});
                send(16'h4200, {16'h0003, 3'b000});
                send(16'h4400, {16'h0004, 3'b000});
                send(16'h4500, {16'h0005, 3'b000});
            end
            begin
                repeat (2) @(negedge clk);
                repeat (3) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                    chk("stall_hold", {13'd0, out_data, out_invalid, out_overflow, out_inexact},
                        {13'd0, 16'h0002, 3'b000});
                end
                sync();
                out_ready = 1'b1;
            end
        join
        repeat (4) sync();
        chk("bp_drained", exp_q.size(), 32'd0);

        // reset with both stages full
        out_ready = 1'b0;
        send(16'h3C00, {16'h0001, 3'b000});
        send(16'h4000, {16'h0002, 3'b000});
        rst = 1'b1;
        exp_q.delete();
        cyc_q.delete();
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_out", {13'd0, out_data, out_invalid, out_overflow, out_inexact}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        sync();
        out_ready = 1'b1;
        lat_on    = 1'b1;

        // single-bit walk at full rate
        send(16'h0000, {16'h0000, 3'b000});
        for (int i = 0; i < 15; i++) begin
            if (i == 14) send(16'h4000, {16'h0002, 3'b000});
            else         send(16'(1 << i), {16'h0000, 3'b001});
        end
        repeat (4) sync();
        chk("final_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
